rom_load_arbiter: RTL and testbench

- Sits between the SPI download front end (ioctl_* byte stream) and the single 16-bit SDRAM/ROM port shared with the core's cartridge bus.
- Packs download bytes into big-endian 16-bit words and throttles the front end through clkref_n.
- Arbitrates the memory port between download writes and core reads, and holds the core in reset while a load is running.
- Reports the loaded ROM size when the load completes.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/loader_word_packer.sv | 98 +++++++++
 rtl/rom_load_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_rom_load_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the ROM download path.
// The LOADER_BYTESWAP_EN build option is consumed by loader_word_packer.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WR,
    GNT_RD
  } grant_t;

  // Byte enables on the 16-bit port; bit 1 selects the high byte.
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_BOTH = 2'b11;

endpackage

// File: rtl/loader_word_packer.sv
// Packs the download byte stream into 16-bit words for the memory port.
// Holds at most one word; throttles the loader via clkref_n while a word
// is waiting for the memory. Build option LOADER_BYTESWAP_EN selects
// little-endian packing (even byte into the low half).
module loader_word_packer
  import loader_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        data_i,
  input  logic              done_i,
  output logic              pend_o,
  output logic              busy_o,
  output logic              accept_o,
  output logic              drop_o,
  output logic              clkref_n_o,
  output logic [ADDR_W-2:0] addr_o,
  output logic [15:0]       data_o,
  output logic [1:0]        be_o
);

`ifdef LOADER_BYTESWAP_EN
  localparam logic SWAP = 1'b1;
`else
  localparam logic SWAP = 1'b0;
`endif
  localparam logic [1:0] FLUSH_BE = SWAP ? BE_LO : BE_HI;

  logic              full_q, full_d;
  logic              half_q, half_d;
  logic [1:0]        be_q, be_d;
  logic [15:0]       hold_q;
  logic [ADDR_W-2:0] waddr_q;

  assign accept_o   = load_i & wr_i & ~full_q;
  assign drop_o     = load_i & wr_i & full_q;
  assign clkref_n_o = ~(load_i & ~full_q);
  assign pend_o     = full_q;
  assign busy_o     = full_q | half_q;
  assign addr_o     = waddr_q;
  assign data_o     = hold_q;
  assign be_o       = be_q;

  // Next-state of the holding register flags and byte enables.
  always_comb begin
    full_d = full_q;
    half_d = half_q;
    be_d   = be_q;
    if (done_i) begin
      full_d = 1'b0;
    end
    if (accept_o) begin
      if (!addr_i[0]) begin
        half_d = 1'b1;
      end else begin
        full_d = 1'b1;
        half_d = 1'b0;
        be_d   = BE_BOTH;
      end
    end else if (flush_i && half_q && !full_q) begin
      full_d = 1'b1;
      half_d = 1'b0;
      be_d   = FLUSH_BE;
    end
  end

  // Control state of the holding register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      half_q <= 1'b0;
      be_q   <= 2'b00;
    end else begin
      full_q <= full_d;
      half_q <= half_d;
      be_q   <= be_d;
    end
  end

  // Byte lanes and word address; the lane is picked by address parity.
  always_ff @(posedge clk_i) begin
    if (accept_o) begin
      waddr_q <= addr_i[ADDR_W-1:1];
      if (addr_i[0] ^ SWAP) begin
        hold_q[7:0] <= data_i;
      end else begin
        hold_q[15:8] <= data_i;
      end
    end
  end

endmodule

// File: rtl/rom_load_arbiter.sv
// ROM download arbiter: sequences a ROM load from the ioctl byte stream,
// shares the single 16-bit memory port between download writes and core
// reads (writes first), holds the core in reset during a load and reports
// the loaded size. Build option LOADER_BYTESWAP_EN (see word packer).
module rom_load_arbiter
  import loader_pkg::*;
#(
  parameter int         ADDR_W     = 24,
  parameter logic [7:0] LOAD_INDEX = 8'h00,
  parameter int         RST_HOLD   = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              clkref_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-2:0] cpu_addr,
  output logic              cpu_ack,
  output logic [15:0]       cpu_dout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-2:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_be,
  input  logic [15:0]       mem_dout,
  input  logic              mem_ack,
  output logic              core_reset,
  output logic [ADDR_W-1:0] rom_size
);

  // Counter value that makes core_reset fall RST_HOLD cycles after DONE.
  localparam logic [15:0] HOLD_INIT = 16'(RST_HOLD - 1);

  state_t            state_q;
  grant_t            grant_q;
  logic              dl_q;
  logic              defer_q;
  logic              err_sticky_q;
  logic              core_reset_q;
  logic [15:0]       hold_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] rom_size_q;

  logic              mem_req_q, mem_we_q, cpu_ack_q;
  logic [ADDR_W-2:0] mem_addr_q;
  logic [15:0]       mem_din_q, cpu_dout_q;
  logic [1:0]        mem_be_q;

  logic              pk_accept, pk_drop, pk_pend, pk_busy, wr_done;
  logic [ADDR_W-2:0] pk_addr;
  logic [15:0]       pk_data;
  logic [1:0]        pk_be;
  logic              dl_rise, idx_ok;
  logic              unused_addr;

  assign dl_rise     = ioctl_download & ~dl_q;
  assign idx_ok      = (ioctl_index == LOAD_INDEX);
  assign wr_done     = mem_ack & (grant_q == GNT_WR);
  assign unused_addr = ^ioctl_addr;

  loader_word_packer #(
    .ADDR_W(ADDR_W)
  ) u_packer (
    .clk_i     (clk_sys),
    .rst_i     (reset),
    .load_i    (state_q == LOAD),
    .flush_i   (state_q == FLUSH),
    .wr_i      (ioctl_wr),
    .addr_i    (ioctl_addr[ADDR_W-1:0]),
    .data_i    (ioctl_dout),
    .done_i    (wr_done),
    .pend_o    (pk_pend),
    .busy_o    (pk_busy),
    .accept_o  (pk_accept),
    .drop_o    (pk_drop),
    .clkref_n_o(clkref_n),
    .addr_o    (pk_addr),
    .data_o    (pk_data),
    .be_o      (pk_be)
  );

  // Load sequencer: start/stop, byte count, size report and core reset hold.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dl_q         <= 1'b0;
      defer_q      <= 1'b0;
      err_sticky_q <= 1'b0;
      core_reset_q <= 1'b1;
      hold_q       <= HOLD_INIT;
      cnt_q        <= '0;
      rom_size_q   <= '0;
    end else begin
      dl_q <= ioctl_download;
      if (pk_drop) begin
        err_sticky_q <= 1'b1;
      end
      if (pk_accept) begin
        cnt_q <= ioctl_addr[ADDR_W-1:0] + ADDR_W'(1);
      end
      if (!ioctl_download) begin
        defer_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (ioctl_download && idx_ok && (!dl_q || defer_q)) begin
            state_q      <= LOAD;
            core_reset_q <= 1'b1;
            cnt_q        <= '0;
            defer_q      <= 1'b0;
          end else if (hold_q > 16'd1) begin
            hold_q <= hold_q - 16'd1;
          end else begin
            hold_q       <= 16'd0;
            core_reset_q <= 1'b0;
          end
        end
        LOAD: begin
          if (!ioctl_download) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          // A new download seen here is started once back in IDLE.
          if (dl_rise && idx_ok) begin
            defer_q <= 1'b1;
          end
          if (!pk_busy) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (dl_rise && idx_ok) begin
            defer_q <= 1'b1;
          end
          rom_size_q <= cnt_q;
          hold_q     <= HOLD_INIT;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory port arbiter: pending write beats a core read; no preemption.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      grant_q    <= GNT_NONE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_be_q   <= 2'b00;
      cpu_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      case (grant_q)
        GNT_NONE: begin
          if (pk_pend) begin
            grant_q    <= GNT_WR;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= pk_addr;
            mem_din_q  <= pk_data;
            mem_be_q   <= pk_be;
          end else if (cpu_req && !cpu_ack_q) begin
            // cpu_req is still high in the ack cycle; do not re-serve it.
            grant_q    <= GNT_RD;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= cpu_addr;
            mem_be_q   <= BE_BOTH;
          end
        end
        default: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            grant_q   <= GNT_NONE;
            if (grant_q == GNT_RD) begin
              cpu_ack_q  <= 1'b1;
              cpu_dout_q <= mem_dout;
            end
          end
        end
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_be     = mem_be_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_dout   = cpu_dout_q;
  assign core_reset = core_reset_q;
  assign rom_size   = rom_size_q;

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter with a two-cycle-latency memory model.
// Expectations follow LOADER_BYTESWAP_EN when it is defined.
module tb_rom_load_arbiter;
  import loader_pkg::*;

  localparam int ADDR_W   = 24;
  localparam int RST_HOLD = 16;

`ifdef LOADER_BYTESWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic              clk_sys;
  logic              reset;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              clkref_n;
  logic              cpu_req;
  logic [ADDR_W-2:0] cpu_addr;
  logic              cpu_ack;
  logic [15:0]       cpu_dout;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-2:0] mem_addr;
  logic [15:0]       mem_din;
  logic [1:0]        mem_be;
  logic [15:0]       mem_dout;
  logic              mem_ack;
  logic              core_reset;
  logic [ADDR_W-1:0] rom_size;

  rom_load_arbiter #(
    .ADDR_W    (ADDR_W),
    .LOAD_INDEX(8'h00),
    .RST_HOLD  (RST_HOLD)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .clkref_n      (clkref_n),
    .cpu_req       (cpu_req),
    .cpu_addr      (cpu_addr),
    .cpu_ack       (cpu_ack),
    .cpu_dout      (cpu_dout),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_be        (mem_be),
    .mem_dout      (mem_dout),
    .mem_ack       (mem_ack),
    .core_reset    (core_reset),
    .rom_size      (rom_size)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transaction log filled by the memory model at each ack.
  logic [ADDR_W-2:0] log_addr[$];
  logic [15:0]       log_din[$];
  logic [1:0]        log_be[$];
  logic              log_we[$];

  // Memory model: ack two cycles after mem_req rises, reads return BEEF.
  int lat = 0;
  always @(negedge clk_sys) begin
    if (reset) begin
      mem_ack = 1'b0;
      lat = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      lat = 0;
    end else if (mem_req) begin
      lat++;
      if (lat == 2) begin
        mem_ack = 1'b1;
        if (!mem_we) mem_dout = 16'hBEEF;
        log_addr.push_back(mem_addr);
        log_din.push_back(mem_din);
        log_be.push_back(mem_be);
        log_we.push_back(mem_we);
      end
    end else begin
      lat = 0;
    end
  end

  function automatic logic [15:0] exp_word(input logic [7:0] e, input logic [7:0] o);
    return SWAP ? {o, e} : {e, o};
  endfunction

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit fall);
    int t = 0;
    while (clkref_n && t < 50) begin
      @(negedge clk_sys);
      t++;
    end
    check_val("clkref_wait_timeout", 32'(t >= 50), 32'd0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (fall) ioctl_download = 1'b0;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_load(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
  endtask

  task automatic wait_state(input state_t s, input string tag);
    int t = 0;
    while (dut.state_q != s && t < 200) begin
      @(negedge clk_sys);
      t++;
    end
    check_val(tag, 32'(t >= 200), 32'd0);
  endtask

  task automatic wait_core_release(input string tag);
    int t = 0;
    while (core_reset && t < 100) begin
      @(negedge clk_sys);
      t++;
    end
    check_val(tag, 32'(t >= 100), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  logic [7:0] t1_bytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] t2_bytes[3] = '{8'hAA, 8'hBB, 8'hCC};

  initial begin
    int base;
    int k;
    int t;
    logic seen_req;
    logic seen_clk;

    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; cpu_req = 1'b0; cpu_addr = '0;
    mem_dout = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk_sys);

    // Reset state
    check_val("rst_clkref_n", 32'(clkref_n), 32'd1);
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_mem_we", 32'(mem_we), 32'd0);
    check_val("rst_mem_be", 32'(mem_be), 32'd0);
    check_val("rst_mem_din", 32'(mem_din), 32'd0);
    check_val("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check_val("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    check_val("rst_core_reset", 32'(core_reset), 32'd1);
    check_val("rst_rom_size", 32'(rom_size), 32'd0);
    check_val("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    wait_core_release("por_release_timeout");

    // T1: four bytes, two full words
    base = log_addr.size();
    start_load(8'h00);
    for (int i = 0; i < 4; i++) begin
      send_byte(25'(i), t1_bytes[i], 1'b0);
      if (i == 0) check_val("t1_core_reset_in_load", 32'(core_reset), 32'd1);
    end
    ioctl_download = 1'b0;
    wait_state(DONE, "t1_done_timeout");
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (core_reset && k < 100);
    check_val("t1_core_reset_hold", 32'(k), 32'(RST_HOLD));
    check_val("t1_rom_size", 32'(rom_size), 32'd4);
    check_val("t1_nwrites", 32'(log_addr.size() - base), 32'd2);
    if (log_addr.size() - base == 2) begin
      check_val("t1_w0_addr", 32'(log_addr[base]), 32'd0);
      check_val("t1_w0_din", 32'(log_din[base]), 32'(exp_word(8'h11, 8'h22)));
      check_val("t1_w0_be", 32'(log_be[base]), 32'd3);
      check_val("t1_w1_addr", 32'(log_addr[base+1]), 32'd1);
      check_val("t1_w1_din", 32'(log_din[base+1]), 32'(exp_word(8'h33, 8'h44)));
      check_val("t1_w1_be", 32'(log_be[base+1]), 32'd3);
    end

    // T2: three bytes, last one arrives with download falling
    base = log_addr.size();
    start_load(8'h00);
    for (int i = 0; i < 3; i++) send_byte(25'(i), t2_bytes[i], i == 2);
    wait_state(DONE, "t2_done_timeout");
    @(negedge clk_sys);
    check_val("t2_rom_size", 32'(rom_size), 32'd3);
    check_val("t2_nwrites", 32'(log_addr.size() - base), 32'd2);
    if (log_addr.size() - base == 2) begin
      check_val("t2_w0_din", 32'(log_din[base]), 32'(exp_word(8'hAA, 8'hBB)));
      check_val("t2_w1_addr", 32'(log_addr[base+1]), 32'd1);
      check_val("t2_w1_byte", 32'(SWAP ? log_din[base+1][7:0] : log_din[base+1][15:8]), 32'hCC);
      check_val("t2_w1_be", 32'(log_be[base+1]), SWAP ? 32'd1 : 32'd2);
    end
    check_val("t2_err_sticky", 32'(dut.err_sticky_q), 32'd0);
    wait_core_release("t2_release_timeout");

    // T3: foreign index is ignored
    base = log_addr.size();
    seen_req = 1'b0;
    seen_clk = 1'b0;
    start_load(8'h01);
    repeat (12) begin
      @(negedge clk_sys);
      seen_req |= mem_req;
      seen_clk |= ~clkref_n;
    end
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk_sys);
    ioctl_index = 8'h00;
    check_val("t3_no_mem_req", 32'(seen_req), 32'd0);
    check_val("t3_clkref_high", 32'(seen_clk), 32'd0);
    check_val("t3_nwrites", 32'(log_addr.size() - base), 32'd0);
    check_val("t3_core_reset", 32'(core_reset), 32'd0);
    check_val("t3_rom_size", 32'(rom_size), 32'd3);
    check_val("t3_state", 32'(dut.state_q), 32'(IDLE));

    // T4: read request arrives as a write becomes pending
    base = log_addr.size();
    start_load(8'h00);
    send_byte(25'd0, 8'h12, 1'b0);
    send_byte(25'd1, 8'h34, 1'b0);
    cpu_addr = 23'd5;
    cpu_req  = 1'b1;
    t = 0;
    while (!cpu_ack && t < 50) begin
      @(negedge clk_sys);
      t++;
    end
    check_val("t4_ack_timeout", 32'(t >= 50), 32'd0);
    check_val("t4_cpu_dout", 32'(cpu_dout), 32'hBEEF);
    cpu_req = 1'b0;
    @(negedge clk_sys);
    check_val("t4_ack_single", 32'(cpu_ack), 32'd0);
    check_val("t4_ntrans", 32'(log_addr.size() - base), 32'd2);
    if (log_addr.size() - base == 2) begin
      check_val("t4_first_we", 32'(log_we[base]), 32'd1);
      check_val("t4_first_din", 32'(log_din[base]), 32'(exp_word(8'h12, 8'h34)));
      check_val("t4_second_we", 32'(log_we[base+1]), 32'd0);
      check_val("t4_second_addr", 32'(log_addr[base+1]), 32'd5);
    end
    ioctl_download = 1'b0;
    wait_state(DONE, "t4_done_timeout");
    @(negedge clk_sys);
    check_val("t4_rom_size", 32'(rom_size), 32'd2);

    // T5: byte while full is dropped, then reset during a write
    start_load(8'h00);
    send_byte(25'd0, 8'h01, 1'b0);
    send_byte(25'd1, 8'h02, 1'b0);
    ioctl_addr = 25'd2;
    ioctl_dout = 8'h55;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check_val("t5_err_sticky", 32'(dut.err_sticky_q), 32'd1);
    t = 0;
    while (!mem_req && t < 20) begin
      @(negedge clk_sys);
      t++;
    end
    check_val("t5_mem_req_timeout", 32'(t >= 20), 32'd0);
    reset = 1'b1;
    @(negedge clk_sys);
    check_val("t5_mem_req", 32'(mem_req), 32'd0);
    check_val("t5_clkref_n", 32'(clkref_n), 32'd1);
    check_val("t5_core_reset", 32'(core_reset), 32'd1);
    check_val("t5_state", 32'(dut.state_q), 32'(IDLE));
    check_val("t5_err_cleared", 32'(dut.err_sticky_q), 32'd0);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;

    // T6: top byte address wraps the byte count
    base = log_addr.size();
    start_load(8'h00);
    send_byte(25'h0FFFFFF, 8'h77, 1'b1);
    wait_state(DONE, "t6_done_timeout");
    @(negedge clk_sys);
    check_val("t6_rom_size", 32'(rom_size), 32'd0);
    check_val("t6_nwrites", 32'(log_addr.size() - base), 32'd1);
    if (log_addr.size() - base == 1) begin
      check_val("t6_addr", 32'(log_addr[base]), 32'h7FFFFF);
      check_val("t6_be", 32'(log_be[base]), 32'd3);
      check_val("t6_byte", 32'(SWAP ? log_din[base][15:8] : log_din[base][7:0]), 32'h77);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
